pipeline_if: RTL and testbench
==============================

Name: pipeline_if

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of instruction decode. Holds the program counter and drives the instruction-memory address. Captures each fetched word with its PC+4 into the IF/ID register, which feeds decode. Supports hazard stall, flush, and branch/jump redirect from downstream stages.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard stall; hold PC and IF/ID
flush  input  1  clear IF/ID to a bubble
redirect  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  32  target address; bits [1:0] ignored
imem_addr  output  32  fetch address; equals the current PC register
imem_rdata  input  32  instruction word; combinational response to imem_addr
imem_ready  input  1  imem_rdata valid this cycle
if_pc  output  32  registered PC+4 of the instruction in IF/ID (to decode pc)
if_instr  output  32  registered instruction (to decode instr)
if_valid  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (synchronous, priority over everything): pc_q=RESET_PC, if_pc=0, if_instr=NOP_INSTR, if_valid=0. Reset asserted mid-fetch discards the in-flight word.
- imem_addr = pc_q, combinational. Fetch latency: a word presented in cycle N appears on if_* in cycle N+1.
- fetch_ok = imem_ready & ~stall.
- PC update priority, applied per edge after reset:
  1. redirect: pc_q <= {redirect_pc[31:2],2'b00}. This overrides stall.
  2. stall: hold.
  3. imem_ready: pc_q <= pc_q+4, with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
  4. Otherwise hold; retry the same address.
- IF/ID update priority, applied per edge after reset:
  1. flush, or redirect (redirect rule modified by the optional feature): if_instr=NOP_INSTR, if_valid=0, if_pc=0. Flush overrides stall.
  2. stall: hold all IF/ID outputs.
  3. imem_ready: if_instr=imem_rdata, if_pc=pc_q+4, if_valid=1.
  4. ~imem_ready: insert bubble (NOP_INSTR, valid=0, if_pc=0).
- Stall with ~imem_ready: the IF/ID register still holds its contents; no bubble is inserted.
- redirect and flush together: same as redirect; IF/ID becomes a bubble.
- Redirect while imem not ready: the PC is retargeted immediately. The pending fetch is abandoned.
- Unaligned pc_q is impossible by construction. Both RESET_PC[1:0] and redirect_pc[1:0] are forced to 0.
- No combinational path from the stall, flush, or redirect inputs to the if_* outputs. imem_addr is combinational only on pc_q.

Optional Feature:
BRANCH_DELAY_SLOT_EN
- Defined: redirect does not squash the IF/ID register. The word fetched in the redirect cycle (the delay slot) is captured per rules 2-4, so MIPS delay-slot semantics apply. flush still bubbles.
- Undefined: redirect bubbles IF/ID as in rule 1 (no delay slot).
- PC behaviour is identical in both builds.

Test Plan:
- Reset then 3 cycles of imem_ready=1, rdata=0x20080005,0x20090003,0x01095020 -> imem_addr 0,4,8. if_* sequence (pc,instr,valid): (4,0x20080005,1), (8,0x20090003,1), (0xC,0x01095020,1).
- stall=1 for 2 cycles at pc_q=0x8 -> imem_addr stays 0x8; if_instr and if_pc hold. On release, fetch resumes at 0x8 with no duplicate and no loss.
- imem_ready=0 for 1 cycle at pc_q=0x10 -> if_valid=0, if_instr=0, pc_q stays 0x10. Next ready cycle captures the word with if_pc=0x14.
- redirect=1, redirect_pc=0x00000043, at pc_q=0x20 -> next pc_q=0x40. IF/ID is a bubble without the feature; with BRANCH_DELAY_SLOT_EN it captures the word from 0x20 with if_pc=0x24.
- stall=1 with flush=1 -> IF/ID becomes a bubble, PC holds. Then reset asserted mid-run -> next cycle pc_q=RESET_PC and if_valid=0.
- PC at 0xFFFFFFFC with imem_ready=1 -> next pc_q=0x00000000 and if_pc=0x00000000.

Source files
------------

// File: rtl/pipeline_if.sv
// -----------------------------------------------------------------------------
// pipeline_if : instruction-fetch stage plus the IF/ID pipeline register.
//
// This stage owns the program counter, which it drives straight onto the
// instruction-memory address. Each fetched word is captured into the IF/ID
// register together with its PC+4. Downstream stages can request a hazard
// stall, a flush, or a branch/jump redirect.
//
// Optional build macro:
//   BRANCH_DELAY_SLOT_EN - when defined, a redirect does not squash IF/ID.
//                          The word fetched in the redirect cycle (the delay
//                          slot) is captured normally. A flush still inserts a
//                          bubble. The PC behaves the same in both builds.
// -----------------------------------------------------------------------------
module pipeline_if #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid
);

   // The low two bits are masked off, so the PC is always word aligned.
   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_target;
   logic        fetch_ok;
   logic        squash;

   logic [31:0] if_pc_q;
   logic [31:0] if_instr_q;
   logic        if_valid_q;

   // The adder wraps modulo 2^32, so 0xFFFFFFFC is followed by 0x00000000.
   assign pc_plus4        = pc_q + 32'd4;
   assign redirect_target = redirect_pc & ~32'h3;
   assign fetch_ok        = imem_ready & ~stall;

`ifdef BRANCH_DELAY_SLOT_EN
   // With a delay slot, only an explicit flush squashes IF/ID.
   assign squash = flush;
`else
   // Without a delay slot, the word fetched alongside a taken branch is wrong-path.
   assign squash = flush | redirect;
`endif

   // Drive the fetch address straight from the PC register.
   assign imem_addr = pc_q;

   // Update the program counter: reset, then redirect (which overrides stall), then advance on a completed fetch.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register sample its pre-edge inputs, so ordering between blocks cannot matter.
      if (reset) begin
         pc_q <= RESET_PC_ALIGNED;
      end else if (redirect) begin
         pc_q <= redirect_target;
      end else if (fetch_ok) begin
         pc_q <= pc_plus4;
      end
   end

   // Update the IF/ID register: reset, then squash, then hold on stall, then capture a word or insert a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_pc_q    <= 32'h0;
         if_instr_q <= NOP_INSTR;
         if_valid_q <= 1'b0;
      end else if (squash) begin
         if_pc_q    <= 32'h0;
         if_instr_q <= NOP_INSTR;
         if_valid_q <= 1'b0;
      end else if (!stall) begin
         if (imem_ready) begin
            if_pc_q    <= pc_plus4;
            if_instr_q <= imem_rdata;
            if_valid_q <= 1'b1;
         end else begin
            if_pc_q    <= 32'h0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
         end
      end
   end

   assign if_pc    = if_pc_q;
   assign if_instr = if_instr_q;
   assign if_valid = if_valid_q;

endmodule

// File: tb/tb_pipeline_if.sv
// -----------------------------------------------------------------------------
// tb_pipeline_if : self-checking bench for pipeline_if.
// Part 1 is a directed vector table with hand-derived expectations.
// Part 2 uses random stimulus checked against a cycle-level reference model.
// Build with +define+BRANCH_DELAY_SLOT_EN to check the delay-slot variant.
// -----------------------------------------------------------------------------
module tb_pipeline_if;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;

   int checks   = 0;
   int failures = 0;

   pipeline_if dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ready (imem_ready),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .if_valid   (if_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stl;
      logic        fl;
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      logic [31:0] rdata;
      logic [31:0] e_addr;   // imem_addr expected after the edge
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_valid;
   } vec_t;

   vec_t vecs[24];

`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   function automatic vec_t mk(input logic rst, stl, fl, rd, input logic [31:0] rpc,
                               input logic rdy, input logic [31:0] rdata,
                               input logic [31:0] e_addr, e_pc, e_instr, input logic e_valid);
      vec_t v;
      v.rst = rst; v.stl = stl; v.fl = fl; v.rd = rd; v.rpc = rpc;
      v.rdy = rdy; v.rdata = rdata;
      v.e_addr = e_addr; v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
   task automatic apply(input logic rst, stl, fl, rd, input logic [31:0] rpc,
                        input logic rdy, input logic [31:0] rdata);
      @(negedge clk);
      reset = rst; stall = stl; flush = fl; redirect = rd;
      redirect_pc = rpc; imem_ready = rdy; imem_rdata = rdata;
      @(posedge clk);
      #1;
   endtask

   // Reference model state: the fetch address, plus the word decode currently sees.
   logic [31:0] m_pc;
   logic [31:0] m_if_pc;
   logic [31:0] m_if_instr;
   logic        m_if_valid;

   // Apply one clock edge of the rules to the model.
   task automatic model_step(input logic rst, stl, fl, rd, input logic [31:0] rpc,
                             input logic rdy, input logic [31:0] rdata);
      logic        completed;
      logic        bubble;
      logic [31:0] fetched_from;
      fetched_from = m_pc;
      completed    = rdy && !stl;
      if (rst) begin
         m_pc = 32'h0;
         bubble = 1'b1;
      end else begin
         // Decide what decode sees next.
         if (fl || (rd && !DS))                  bubble = 1'b1;
         else if (stl)                           bubble = 1'b0;   // held below
         else if (rdy)                           bubble = 1'b0;
         else                                    bubble = 1'b1;
         if (!bubble && !stl) begin
            m_if_pc    = fetched_from + 32'd4;
            m_if_instr = rdata;
            m_if_valid = 1'b1;
         end
         // Decide where the next fetch goes.
         if (rd)             m_pc = {rpc[31:2], 2'b00};
         else if (completed) m_pc = fetched_from + 32'd4;
      end
      if (bubble) begin
         m_if_pc = 32'h0; m_if_instr = 32'h0; m_if_valid = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
      redirect_pc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;

      // Reset state, with a live fetch that must be discarded.
      apply(1, 0, 0, 0, 32'h0, 1, 32'hCAFE_F00D);
      check("reset_addr",  imem_addr, 32'h0);
      check("reset_pc",    if_pc, 32'h0);
      check("reset_instr", if_instr, 32'h0);
      check("reset_valid", {31'h0, if_valid}, 32'h0);

      //            rst stl fl rd  rpc           rdy rdata          addr           if_pc          if_instr       valid
      vecs[0]  = mk(0,  0,  0, 0, 32'h0,        1, 32'h2008_0005, 32'h0000_0004, 32'h0000_0004, 32'h2008_0005, 1);
      vecs[1]  = mk(0,  0,  0, 0, 32'h0,        1, 32'h2009_0003, 32'h0000_0008, 32'h0000_0008, 32'h2009_0003, 1);
      vecs[2]  = mk(0,  0,  0, 0, 32'h0,        1, 32'h0109_5020, 32'h0000_000C, 32'h0000_000C, 32'h0109_5020, 1);
      vecs[3]  = mk(0,  1,  0, 0, 32'h0,        1, 32'hDEAD_BEEF, 32'h0000_000C, 32'h0000_000C, 32'h0109_5020, 1);
      vecs[4]  = mk(0,  1,  0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h0000_000C, 32'h0000_000C, 32'h0109_5020, 1);
      vecs[5]  = mk(0,  0,  0, 0, 32'h0,        1, 32'h1111_1111, 32'h0000_0010, 32'h0000_0010, 32'h1111_1111, 1);
      vecs[6]  = mk(0,  0,  0, 0, 32'h0,        0, 32'hBAD0_BAD0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 0);
      vecs[7]  = mk(0,  0,  0, 0, 32'h0,        1, 32'h2222_2222, 32'h0000_0014, 32'h0000_0014, 32'h2222_2222, 1);
      vecs[8]  = mk(0,  0,  0, 0, 32'h0,        1, 32'h3333_3333, 32'h0000_0018, 32'h0000_0018, 32'h3333_3333, 1);
      vecs[9]  = mk(0,  0,  0, 0, 32'h0,        1, 32'h4444_4444, 32'h0000_001C, 32'h0000_001C, 32'h4444_4444, 1);
      vecs[10] = mk(0,  0,  0, 0, 32'h0,        1, 32'h5555_5555, 32'h0000_0020, 32'h0000_0020, 32'h5555_5555, 1);
      if (DS)
         vecs[11] = mk(0, 0, 0, 1, 32'h0000_0043, 1, 32'h6666_6666, 32'h0000_0040, 32'h0000_0024, 32'h6666_6666, 1);
      else
         vecs[11] = mk(0, 0, 0, 1, 32'h0000_0043, 1, 32'h6666_6666, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 0);
      vecs[12] = mk(0,  0,  0, 0, 32'h0,        1, 32'h7777_7777, 32'h0000_0044, 32'h0000_0044, 32'h7777_7777, 1);
      vecs[13] = mk(0,  0,  0, 1, 32'h0000_0101, 0, 32'hBAD1_BAD1, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0);
      vecs[14] = mk(0,  0,  0, 0, 32'h0,        1, 32'h8888_8888, 32'h0000_0104, 32'h0000_0104, 32'h8888_8888, 1);
      vecs[15] = mk(0,  1,  1, 0, 32'h0,        1, 32'h9999_9999, 32'h0000_0104, 32'h0000_0000, 32'h0000_0000, 0);
      vecs[16] = mk(0,  0,  0, 0, 32'h0,        1, 32'hAAAA_AAAA, 32'h0000_0108, 32'h0000_0108, 32'hAAAA_AAAA, 1);
      vecs[17] = mk(0,  0,  1, 1, 32'h0000_0202, 1, 32'hBBBB_BBBB, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 0);
      vecs[18] = mk(0,  1,  0, 1, 32'hFFFF_FFFF, 1, 32'hCCCC_CCCC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0);
      vecs[19] = mk(0,  0,  0, 0, 32'h0,        1, 32'hDDDD_DDDD, 32'h0000_0000, 32'h0000_0000, 32'hDDDD_DDDD, 1);
      vecs[20] = mk(0,  0,  0, 0, 32'h0,        1, 32'hEEEE_EEEE, 32'h0000_0004, 32'h0000_0004, 32'hEEEE_EEEE, 1);
      vecs[21] = mk(1,  0,  0, 1, 32'h0000_0300, 1, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0);
      vecs[22] = mk(0,  0,  0, 0, 32'h0,        1, 32'h1234_5678, 32'h0000_0004, 32'h0000_0004, 32'h1234_5678, 1);
      vecs[23] = mk(0,  1,  0, 0, 32'h0,        0, 32'h0BAD_0BAD, 32'h0000_0004, 32'h0000_0004, 32'h1234_5678, 1);

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].stl, vecs[i].fl, vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].rdata);
         check($sformatf("vec%0d_addr", i),  imem_addr, vecs[i].e_addr);
         check($sformatf("vec%0d_pc", i),    if_pc, vecs[i].e_pc);
         check($sformatf("vec%0d_instr", i), if_instr, vecs[i].e_instr);
         check($sformatf("vec%0d_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].e_valid});
      end

      // Random stimulus against the reference model.
      apply(1, 0, 0, 0, 32'h0, 0, 32'h0);
      m_pc = 32'h0; m_if_pc = 32'h0; m_if_instr = 32'h0; m_if_valid = 1'b0;
      for (int n = 0; n < 500; n++) begin
         logic        r_rst, r_stl, r_fl, r_rd, r_rdy;
         logic [31:0] r_rpc, r_rdata;
         r_rst   = ($urandom_range(0, 49) == 0);
         r_stl   = ($urandom_range(0, 4) == 0);
         r_fl    = ($urandom_range(0, 7) == 0);
         r_rd    = ($urandom_range(0, 7) == 0);
         r_rdy   = ($urandom_range(0, 3) != 0);
         r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         r_rdata = $urandom;
         apply(r_rst, r_stl, r_fl, r_rd, r_rpc, r_rdy, r_rdata);
         model_step(r_rst, r_stl, r_fl, r_rd, r_rpc, r_rdy, r_rdata);
         check($sformatf("rnd%0d_addr", n),  imem_addr, m_pc);
         check($sformatf("rnd%0d_pc", n),    if_pc, m_if_pc);
         check($sformatf("rnd%0d_instr", n), if_instr, m_if_instr);
         check($sformatf("rnd%0d_valid", n), {31'h0, if_valid}, {31'h0, m_if_valid});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
